// File: rtl/uart_json_cmd_rx.sv
// 8N1 UART receiver feeding a fixed-template parser for {"T":d,"L":[-]d.d,"R":[-]d.d}\n frames.
// Decoded fields load into the outputs atomically on each good frame.
module uart_json_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [3:0] cmd_t,
  output logic       l_neg,
  output logic [3:0] l_int,
  output logic [3:0] l_frac,
  output logic       r_neg,
  output logic [3:0] r_int,
  output logic [3:0] r_frac,
  output logic       frame_valid,
  output logic       frame_error
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] LBrace = 8'h7B;
  localparam logic [7:0] Minus  = 8'h2D;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic {PsHunt, PsMatch} ps_state_e;

  typedef struct packed {
    logic [3:0] t;
    logic       ln;
    logic [3:0] li;
    logic [3:0] lf;
    logic       rn;
    logic [3:0] ri;
    logic [3:0] rf;
  } frame_t;

  // Fixed literal bytes of the template, indexed by position after '{'.
  function automatic logic [7:0] lit_char(input logic [4:0] i);
    case (i)
      5'd0, 5'd2, 5'd6, 5'd8, 5'd15, 5'd17: lit_char = 8'h22;
      5'd1:                                 lit_char = 8'h54;
      5'd3, 5'd9, 5'd18:                    lit_char = 8'h3A;
      5'd5, 5'd14:                          lit_char = 8'h2C;
      5'd7:                                 lit_char = 8'h4C;
      5'd12, 5'd21:                         lit_char = 8'h2E;
      5'd16:                                lit_char = 8'h52;
      5'd23:                                lit_char = 8'h7D;
      5'd24:                                lit_char = 8'h0A;
      default:                              lit_char = 8'h00;
    endcase
  endfunction

  logic [1:0]      sync_q, sync_d;
  logic            line_prev_q;
  logic            line, fall;
  rx_state_e       rx_st_q, rx_st_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_ok, stop_err;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q;
  ps_state_e       ps_q, ps_d;
  logic [4:0]      idx_q, idx_d;
  frame_t          sh_q, sh_d, out_q, out_d;
  logic            perr, load, timeout, is_dig;
  logic [3:0]      dig;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            frame_valid_q, frame_error_q;

  assign sync_d = {sync_q[0], uart_in};
  assign line   = sync_q[1];
  assign fall   = line_prev_q & ~line;

  always_comb begin
    rx_st_d   = rx_st_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_ok   = 1'b0;
    stop_err  = 1'b0;
    unique case (rx_st_q)
      RxIdle: begin
        if (fall) begin
          rx_st_d   = RxStart;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      RxStart: begin
        if (clk_cnt_q == HalfLast) begin
          clk_cnt_d = '0;
          rx_st_d   = line ? RxIdle : RxData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          shift_d   = {line, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) rx_st_d = RxStop;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          rx_st_d   = RxIdle;
          byte_ok   = line;
          stop_err  = ~line;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: rx_st_d = RxIdle;
    endcase
  end

  assign rx_data_d = byte_ok ? shift_q : rx_data_q;
  assign is_dig    = (rx_data_q >= 8'h30) && (rx_data_q <= 8'h39);
  assign dig       = rx_data_q[3:0];

  // Idle timer only runs while a frame is open and no byte is in flight.
  always_comb begin
    tmo_d   = tmo_q;
    timeout = 1'b0;
    if (rx_valid_q || (ps_q == PsHunt)) begin
      tmo_d = '0;
    end else if (rx_st_q == RxIdle) begin
      if (tmo_q == TmoLast) begin
        timeout = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_comb begin
    ps_d  = ps_q;
    idx_d = idx_q;
    sh_d  = sh_q;
    perr  = 1'b0;
    load  = 1'b0;
    if (stop_err || timeout) begin
      ps_d  = PsHunt;
      idx_d = '0;
    end else if (rx_valid_q) begin
      if (ps_q == PsHunt) begin
        if (rx_data_q == LBrace) begin
          ps_d  = PsMatch;
          idx_d = '0;
        end
      end else begin
        idx_d = idx_q + 5'd1;
        case (idx_q)
          5'd4: begin
            sh_d.t = dig;
            perr   = ~is_dig;
          end
          5'd10, 5'd19: begin
            // Sign slot: '-' consumes a byte, otherwise this is already the integer digit.
            if (rx_data_q == Minus) begin
              if (idx_q == 5'd10) sh_d.ln = 1'b1;
              else                sh_d.rn = 1'b1;
            end else begin
              perr  = ~is_dig;
              idx_d = idx_q + 5'd2;
              if (idx_q == 5'd10) begin
                sh_d.ln = 1'b0;
                sh_d.li = dig;
              end else begin
                sh_d.rn = 1'b0;
                sh_d.ri = dig;
              end
            end
          end
          5'd11, 5'd20: begin
            perr = ~is_dig;
            if (idx_q == 5'd11) sh_d.li = dig;
            else                sh_d.ri = dig;
          end
          5'd13, 5'd22: begin
            perr = ~is_dig;
            if (idx_q == 5'd13) sh_d.lf = dig;
            else                sh_d.rf = dig;
          end
          default: begin
            perr = (rx_data_q != lit_char(idx_q));
            if ((idx_q == 5'd24) && !perr) begin
              load  = 1'b1;
              ps_d  = PsHunt;
              idx_d = '0;
            end
          end
        endcase
        if (perr) begin
          idx_d = '0;
          ps_d  = (rx_data_q == LBrace) ? PsMatch : PsHunt;
        end
      end
    end
  end

  always_comb begin
    out_d = out_q;
    if (load) begin
      out_d    = sh_q;
      out_d.ln = sh_q.ln & (|{sh_q.li, sh_q.lf});
      out_d.rn = sh_q.rn & (|{sh_q.ri, sh_q.rf});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= 2'b11;
      line_prev_q   <= 1'b1;
      rx_st_q       <= RxIdle;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      ps_q          <= PsHunt;
      idx_q         <= '0;
      sh_q          <= '0;
      out_q         <= '0;
      tmo_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      line_prev_q   <= line;
      rx_st_q       <= rx_st_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= byte_ok;
      ps_q          <= ps_d;
      idx_q         <= idx_d;
      sh_q          <= sh_d;
      out_q         <= out_d;
      tmo_q         <= tmo_d;
      frame_valid_q <= load;
      frame_error_q <= perr | stop_err | timeout;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign cmd_t       = out_q.t;
  assign l_neg       = out_q.ln;
  assign l_int       = out_q.li;
  assign l_frac      = out_q.lf;
  assign r_neg       = out_q.rn;
  assign r_int       = out_q.ri;
  assign r_frac      = out_q.rf;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_json_cmd_rx.sv
// Bench for uart_json_cmd_rx: serial frames from numeric values, outputs checked against
// values derived directly from the numbers that built each frame.
module tb_uart_json_cmd_rx;

  localparam int unsigned Cpb = 8;
  localparam int unsigned Tmo = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] cmd_t, l_int, l_frac, r_int, r_frac;
  logic       l_neg, r_neg, frame_valid, frame_error;
  logic [21:0] got_out;

  uart_json_cmd_rx #(
    .CLKS_PER_BIT(Cpb),
    .TIMEOUT_CLKS(Tmo)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_in    (uart_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_t      (cmd_t),
    .l_neg      (l_neg),
    .l_int      (l_int),
    .l_frac     (l_frac),
    .r_neg      (r_neg),
    .r_int      (r_int),
    .r_frac     (r_frac),
    .frame_valid(frame_valid),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  assign got_out = {cmd_t, l_neg, l_int, l_frac, r_neg, r_int, r_frac};

  int n_checks = 0;
  int n_fail = 0;
  int n_rxv = 0, n_fv = 0, n_fe = 0;
  int cyc = 0, last_rxv_cyc = 0, last_fe_cyc = 0;
  byte unsigned rx_log[$];
  logic [21:0] exp_out = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (rx_valid) begin
        n_rxv++;
        last_rxv_cyc = cyc;
        rx_log.push_back(rx_data);
      end
      if (frame_valid) n_fv++;
      if (frame_error) begin
        n_fe++;
        last_fe_cyc = cyc;
      end
      if (frame_valid || frame_error) begin
        n_checks++;
        if (frame_valid && frame_error) begin
          n_fail++;
          $display("FAIL excl: frame_valid=%0b frame_error=%0b both high at cycle %0d, required not both",
                   frame_valid, frame_error, cyc);
        end
      end
    end
  end

  // Reported value: sign dropped when the magnitude is zero.
  function automatic logic [21:0] model_out(int t, bit ln, int li, int lf, bit rn, int ri, int rf);
    bit eln, ern;
    eln = ln && ((li != 0) || (lf != 0));
    ern = rn && ((ri != 0) || (rf != 0));
    return {4'(t), eln, 4'(li), 4'(lf), ern, 4'(ri), 4'(rf)};
  endfunction

  function automatic string frame_str(int t, bit ln, int li, int lf, bit rn, int ri, int rf);
    string ls, rs;
    ls = ln ? "-" : "";
    rs = rn ? "-" : "";
    return $sformatf("{\"T\":%0d,\"L\":%s%0d.%0d,\"R\":%s%0d.%0d}\n", t, ls, li, lf, rs, ri, rf);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_hi);
    uart_in = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (Cpb) @(negedge clk);
    end
    uart_in = stop_hi;
    repeat (Cpb) @(negedge clk);
    uart_in = 1'b1;
    if (!stop_hi) repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic settle();
    repeat (3 * Cpb) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    uart_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({got_out, rx_data, rx_valid, frame_valid, frame_error} !== '0) begin
      n_fail++;
      $display("FAIL reset: outputs=%h rx_data=%h pulses=%b%b%b, required all 0",
               got_out, rx_data, rx_valid, frame_valid, frame_error);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    string s;
    int rx0, fv0, fe0;
    logic [7:0] eb;
    s = frame_str(1, 0, 0, 5, 0, 0, 5);
    rx0 = n_rxv; fv0 = n_fv; fe0 = n_fe;
    rx_log.delete();
    send_str(s);
    settle();
    exp_out = model_out(1, 0, 0, 5, 0, 0, 5);
    n_checks++;
    if (n_rxv - rx0 != 24) begin
      n_fail++; $display("FAIL basic_rx_count: got %0d, required 24", n_rxv - rx0);
    end
    n_checks++;
    if (n_fv - fv0 != 1 || n_fe - fe0 != 0) begin
      n_fail++; $display("FAIL basic_pulses: fv=%0d fe=%0d, required 1/0", n_fv - fv0, n_fe - fe0);
    end
    n_checks++;
    if (got_out !== exp_out) begin
      n_fail++; $display("FAIL basic_out: got %h, required %h", got_out, exp_out);
    end
    for (int i = 0; i < s.len() && i < rx_log.size(); i++) begin
      eb = s[i];
      n_checks++;
      if (rx_log[i] !== eb) begin
        n_fail++; $display("FAIL basic_byte%0d: got %h, required %h", i, rx_log[i], eb);
      end
    end
  endtask

  task automatic test_back_to_back();
    send_str(frame_str(1, 1, 0, 3, 0, 0, 7));
    settle();
    exp_out = model_out(1, 1, 0, 3, 0, 0, 7);
    n_checks++;
    if (got_out !== exp_out) begin
      n_fail++; $display("FAIL b2b_first: got %h, required %h", got_out, exp_out);
    end
    send_str(frame_str(1, 0, 0, 2, 1, 0, 9));
    settle();
    exp_out = model_out(1, 0, 0, 2, 1, 0, 9);
    n_checks++;
    if (got_out !== exp_out) begin
      n_fail++; $display("FAIL b2b_second: got %h, required %h", got_out, exp_out);
    end
  endtask

  task automatic test_parse_error();
    int fv0, fe0;
    fv0 = n_fv; fe0 = n_fe;
    send_str("{\"T\":1,\"L\":0.X");
    settle();
    n_checks++;
    if (n_fe - fe0 != 1 || n_fv - fv0 != 0) begin
      n_fail++; $display("FAIL perr_pulse: fe=%0d fv=%0d, required 1/0", n_fe - fe0, n_fv - fv0);
    end
    n_checks++;
    if (got_out !== exp_out) begin
      n_fail++; $display("FAIL perr_hold: got %h, required %h", got_out, exp_out);
    end
    send_str(frame_str(2, 1, 0, 0, 0, 1, 0));
    settle();
    exp_out = model_out(2, 1, 0, 0, 0, 1, 0);
    n_checks++;
    if (got_out !== exp_out || n_fe - fe0 != 1) begin
      n_fail++; $display("FAIL perr_recover: got %h fe=%0d, required %h fe=1",
                         got_out, n_fe - fe0, exp_out);
    end
  endtask

  task automatic test_framing();
    int rx0, fv0, fe0;
    rx0 = n_rxv; fv0 = n_fv; fe0 = n_fe;
    send_str("{\"T\":1,");
    send_byte(8'h22, 1'b0);
    settle();
    n_checks++;
    if (n_rxv - rx0 != 7 || n_fe - fe0 != 1) begin
      n_fail++; $display("FAIL framing: rx=%0d fe=%0d, required 7/1", n_rxv - rx0, n_fe - fe0);
    end
    // A valid tail is only completable if the parser did not return to hunting.
    send_str(":5,\"R\":0.5}\n");
    settle();
    n_checks++;
    if (n_fv - fv0 != 0 || n_fe - fe0 != 1 || got_out !== exp_out) begin
      n_fail++; $display("FAIL framing_hunt: fv=%0d fe=%0d out=%h, required 0/1 %h",
                         n_fv - fv0, n_fe - fe0, got_out, exp_out);
    end
    send_str(frame_str(3, 0, 4, 1, 1, 2, 6));
    settle();
    exp_out = model_out(3, 0, 4, 1, 1, 2, 6);
    n_checks++;
    if (got_out !== exp_out || n_fv - fv0 != 1) begin
      n_fail++; $display("FAIL framing_recover: got %h fv=%0d, required %h fv=1",
                         got_out, n_fv - fv0, exp_out);
    end
  endtask

  task automatic test_timeout();
    int fe0, gap;
    send_str("{\"T\":1,");
    fe0 = n_fe;
    repeat (500) @(negedge clk);
    gap = last_fe_cyc - last_rxv_cyc;
    n_checks++;
    if (n_fe - fe0 != 1) begin
      n_fail++; $display("FAIL timeout_count: got %0d errors, required 1", n_fe - fe0);
    end
    n_checks++;
    if (gap < 398 || gap > 404) begin
      n_fail++; $display("FAIL timeout_time: error %0d cycles after last byte, required ~400", gap);
    end
    send_str(frame_str(5, 1, 9, 9, 0, 8, 1));
    settle();
    exp_out = model_out(5, 1, 9, 9, 0, 8, 1);
    n_checks++;
    if (got_out !== exp_out) begin
      n_fail++; $display("FAIL timeout_recover: got %h, required %h", got_out, exp_out);
    end
  endtask

  task automatic test_glitch_reset();
    int rx0, fe0;
    string s;
    logic [7:0] b;
    rx0 = n_rxv; fe0 = n_fe;
    uart_in = 1'b0;
    repeat (3) @(negedge clk);
    uart_in = 1'b1;
    repeat (5 * Cpb) @(negedge clk);
    n_checks++;
    if (n_rxv - rx0 != 0 || n_fe - fe0 != 0) begin
      n_fail++; $display("FAIL glitch: rx=%0d fe=%0d, required 0/0", n_rxv - rx0, n_fe - fe0);
    end
    s = frame_str(7, 0, 3, 3, 0, 3, 3);
    for (int i = 0; i < 9; i++) send_byte(s[i], 1'b1);
    b = s[9];
    uart_in = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_in = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rst = 1'b1;
    uart_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({got_out, rx_data, rx_valid, frame_valid, frame_error} !== '0) begin
      n_fail++; $display("FAIL midreset: outputs=%h rx_data=%h, required 0", got_out, rx_data);
    end
    rst = 1'b0;
    rx0 = n_rxv; fe0 = n_fe;
    repeat (20 * Cpb) @(negedge clk);
    n_checks++;
    if (n_rxv - rx0 != 0 || n_fe - fe0 != 0 || got_out !== '0) begin
      n_fail++; $display("FAIL postreset: rx=%0d fe=%0d out=%h, required 0/0/0",
                         n_rxv - rx0, n_fe - fe0, got_out);
    end
    send_str(frame_str(4, 1, 0, 6, 1, 5, 0));
    settle();
    exp_out = model_out(4, 1, 0, 6, 1, 5, 0);
    n_checks++;
    if (got_out !== exp_out) begin
      n_fail++; $display("FAIL reset_recover: got %h, required %h", got_out, exp_out);
    end
  endtask

  task automatic test_random();
    int fv0, fe0, t, li, lf, ri, rf;
    bit ln, rn;
    logic [7:0] g;
    fv0 = n_fv; fe0 = n_fe;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'h7B) g = 8'h41;
        send_byte(g, 1'b1);
      end
      t  = $urandom_range(0, 9);  ln = 1'($urandom_range(0, 1));
      li = $urandom_range(0, 9);  lf = $urandom_range(0, 9);
      rn = 1'($urandom_range(0, 1));
      ri = $urandom_range(0, 9);  rf = $urandom_range(0, 9);
      if (k == 0) begin li = 0; lf = 0; ln = 1; end
      send_str(frame_str(t, ln, li, lf, rn, ri, rf));
      settle();
      exp_out = model_out(t, ln, li, lf, rn, ri, rf);
      n_checks++;
      if (got_out !== exp_out) begin
        n_fail++; $display("FAIL random%0d: got %h, required %h", k, got_out, exp_out);
      end
    end
    n_checks++;
    if (n_fv - fv0 != 8 || n_fe - fe0 != 0) begin
      n_fail++; $display("FAIL random_pulses: fv=%0d fe=%0d, required 8/0", n_fv - fv0, n_fe - fe0);
    end
  endtask

  initial begin
    rst = 1'b1;
    uart_in = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_parse_error();
    test_framing();
    test_timeout();
    test_glitch_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_json_cmd_rx.md
Name: uart_json_cmd_rx

Overview:
- Receiving end of the motor-command UART link.
- Deserialises 8N1 bytes from a serial line and parses the fixed JSON command frame `{"T":<d>,"L":[-]<d>.<d>,"R":[-]<d>.<d>}\n`.
- Presents the decoded command type and per-wheel signed speeds as registered outputs, updated atomically per good frame.
- Used on the motor-controller side, and as a loopback checker for the command transmitter.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4.
- TIMEOUT_CLKS, 50000, clk cycles of line idle mid-frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- uart_in  in  1  serial input, idle high, asynchronous to clk
- rx_data  out  8  last received byte
- rx_valid  out  1  one-cycle pulse when rx_data is updated
- cmd_t  out  4  decoded T digit (0-9)
- l_neg  out  1  left wheel negative
- l_int  out  4  left integer digit
- l_frac  out  4  left tenths digit
- r_neg  out  1  right wheel negative
- r_int  out  4  right integer digit
- r_frac  out  4  right tenths digit
- frame_valid  out  1  one-cycle pulse when the speed outputs update
- frame_error  out  1  one-cycle pulse on parse, framing or timeout abort

Behaviour:

Reset:
- All outputs are 0.
- Byte receiver is in IDLE; parser is in HUNT; all counters are 0.
- Reset asserted mid-byte or mid-frame discards all partial data immediately.

Input synchronisation:
- uart_in passes through a 2-flop synchroniser; the sync FFs reset to 1.
- A falling edge is detected on the synchronised signal.

Byte receiver states IDLE -> START -> DATA -> STOP:
- IDLE: a falling edge enters START with bit counter 0.
- START: wait CLKS_PER_BIT/2 (integer division) cycles.
  - If the line is still low, enter DATA.
  - Otherwise it was a glitch: return to IDLE with no pulse.
- DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first.
- STOP: sample once after CLKS_PER_BIT cycles.
  - High: the cycle after the sample, rx_data is updated and rx_valid pulses.
  - Low: framing error. No rx_valid; frame_error pulses; parser forced to HUNT.
  - Either way, return to IDLE. A new start edge is accepted from the cycle after the stop sample.

Parser:
- Consumes one byte per rx_valid. Holds a template index 0..N and a shadow set of field registers.
- HUNT: waits for '{' (0x7B), then goes to MATCH expecting '"'.
- Expected sequence:
  - literals `"T":`
  - T digit
  - literals `,"L":`
  - L field
  - literals `,"R":`
  - R field
  - literals `}` then 0x0A
- Literal mismatch or non-digit in a digit slot: frame_error pulses and the frame is discarded.
  - If the offending byte is '{', the parser re-enters MATCH as a new frame start.
  - Otherwise it goes to HUNT.
- Digit slots accept 0x30-0x39 only; the stored value is byte - 0x30, 4 bits wide.
- Signed field (L and R): first byte '-' (0x2D) sets shadow neg=1 and then expects a digit. Otherwise the byte must be a digit and neg=0.
  - Then expects '.' (0x2E), then the tenths digit.
  - A second '-' is an error.
- Negative zero: -0.0 is reported with neg=0.
- Final 0x0A accepted: the cycle after its rx_valid, all seven outputs cmd_t, l_*, r_* load from shadow together, frame_valid pulses, and the parser returns to HUNT.
- Outputs hold their values between good frames; errors never change them.

Timeout:
- The counter runs when the parser is not in HUNT and the byte receiver is IDLE; it clears on every rx_valid.
- Reaching TIMEOUT_CLKS: frame_error pulses and the parser goes to HUNT.

Other rules:
- frame_error and frame_valid never assert in the same cycle.
- Simultaneous framing error and timeout produce a single one-cycle error pulse.
- Bytes arriving while in HUNT other than '{' are ignored with no error.

Test Plan:
(Use CLKS_PER_BIT=8 and TIMEOUT_CLKS=400 for all scenarios.)
1. Send `{"T":1,"L":0.5,"R":0.5}\n` -> 24 rx_valid pulses; one frame_valid; cmd_t=1, l_neg=0, l_int=0, l_frac=5, r_neg=0, r_int=0, r_frac=5.
2. Send `{"T":1,"L":-0.3,"R":0.7}\n`, then `{"T":1,"L":0.2,"R":-0.9}\n` -> after frame 1: l_neg=1, l_frac=3, r_frac=7; after frame 2: l_neg=0, l_frac=2, r_neg=1, r_frac=9.
3. Send `{"T":1,"L":0.X` then `{"T":2,"L":-0.0,"R":1.0}\n` -> one frame_error at 'X'; outputs unchanged until the second frame; then cmd_t=2, l_neg=0, l_int=0, r_int=1, r_frac=0.
4. Send a byte with its stop bit driven low mid-frame -> no rx_valid for that byte, one frame_error, parser in HUNT; the next full frame decodes correctly.
5. Send `{"T":1,` then hold the line idle for 500 cycles -> frame_error pulses once, at 400 idle cycles; a following full frame decodes.
6. Send a 3-cycle low glitch on an idle line -> no rx_valid. Separately, assert rst in the middle of frame byte 10 -> all outputs 0; the next full frame decodes correctly.
